// File: rtl/riscv_mc_control_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit: opcodes, states,
// mux-select/aluop codes and the per-state control word.
package riscv_mc_control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_WB_ALU, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        OPC_R, OPC_I, OPC_MEM, OPC_BRANCH, OPC_JAL, OPC_ILLEGAL
    } opclass_t;

    // fetch/branch mark the two states whose PC write depends on a live input
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       branch;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic       hasfunct7;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.aluop     = ALUOP_FUNCT;
                c.hasfunct7 = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_FUNCT;
            end
            S_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_ALUOUT;
            end
            S_ADDR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.aluop     = ALUOP_SUB;
                c.pc_src    = 1'b1;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WB_PC4;
                c.pc_write   = 1'b1;
                c.pc_src     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_mc_control_opdecode.sv
// Combinational opcode classifier for the multi-cycle control unit.
module riscv_opdecode
    import riscv_mc_control_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   opclass
);

    always_comb begin
        opclass = OPC_ILLEGAL;
        case (opcode)
            OP_R:              opclass = OPC_R;
            OP_I:              opclass = OPC_I;
            OP_LOAD, OP_STORE: opclass = OPC_MEM;
            OP_BRANCH:         opclass = OPC_BRANCH;
            OP_JAL:            opclass = OPC_JAL;
            default:           opclass = OPC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle RISC-V control FSM with registered control word.
// Optional performance counters are enabled by defining RISCV_PERF_CNT_EN.
module riscv_mc_control
    import riscv_mc_control_pkg::*;
#(
    parameter int TRAP_HALT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        reg_write_o,
    output logic [1:0]  mem_to_reg_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  aluop_o,
    output logic        hasfunct7_o,
    output logic        illegal_o,
    output logic [31:0] instret_o,
    output logic [31:0] cycle_o
);

    state_t   state, next_state;
    ctrl_t    ctrl;
    opclass_t opclass;
    logic     illegal;

    riscv_opdecode u_opdecode (
        .opcode  (opcode_i),
        .opclass (opclass)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready_i) next_state = S_DECODE;
            S_DECODE: begin
                case (opclass)
                    OPC_R:      next_state = S_EXEC_R;
                    OPC_I:      next_state = S_EXEC_I;
                    OPC_MEM:    next_state = S_ADDR;
                    OPC_BRANCH: next_state = S_BRANCH;
                    OPC_JAL:    next_state = S_JAL;
                    default:    next_state = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
            S_ADDR:   next_state = opcode_i[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready_i) next_state = S_MEM_WB;
            S_MEM_WR: if (mem_ready_i) next_state = S_FETCH;
            S_MEM_WB, S_WB_ALU, S_BRANCH, S_JAL: next_state = S_FETCH;
            S_TRAP:   next_state = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Control word is decoded from the next state so it lines up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_FETCH;
            ctrl    <= state_ctrl(S_FETCH);
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            ctrl  <= state_ctrl(next_state);
            if (next_state == S_TRAP) illegal <= 1'b1;
        end
    end

    assign mem_req_o    = ctrl.mem_req;
    assign mem_read_o   = ctrl.mem_read;
    assign mem_write_o  = ctrl.mem_write;
    assign ir_write_o   = ctrl.fetch & mem_ready_i;
    assign pc_write_o   = ctrl.pc_write | (ctrl.fetch & mem_ready_i) | (ctrl.branch & zero_i);
    assign pc_src_o     = ctrl.pc_src;
    assign reg_write_o  = ctrl.reg_write;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign alu_src_a_o  = ctrl.alu_src_a;
    assign alu_src_b_o  = ctrl.alu_src_b;
    assign aluop_o      = ctrl.aluop;
    assign hasfunct7_o  = ctrl.hasfunct7;
    assign illegal_o    = illegal;

`ifdef RISCV_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
    logic        retire;

    // An instruction retires when a completing state hands back to FETCH.
    assign retire = (next_state == S_FETCH) &&
                    ((state == S_WB_ALU) || (state == S_MEM_WB) || (state == S_MEM_WR) ||
                     (state == S_BRANCH) || (state == S_JAL));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instret_cnt <= instret_cnt + 32'd1;
        end
    end

    assign cycle_o   = cycle_cnt;
    assign instret_o = instret_cnt;
`else
    assign cycle_o   = '0;
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// Randomized self-checking bench for riscv_mc_control (both TRAP_HALT settings).
module tb_riscv_mc_control;

`ifdef RISCV_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OPC_ADD   = 7'b0110011;
    localparam logic [6:0] OPC_ADDI  = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       ready = 1'b0;

    logic h_mem_req, h_mem_read, h_mem_write, h_ir_write, h_pc_write, h_pc_src, h_reg_write;
    logic [1:0] h_mem_to_reg, h_alu_src_a, h_alu_src_b, h_aluop;
    logic h_hasfunct7, h_illegal;
    logic [31:0] h_instret, h_cycle;

    logic s_mem_req, s_mem_read, s_mem_write, s_ir_write, s_pc_write, s_pc_src, s_reg_write;
    logic [1:0] s_mem_to_reg, s_alu_src_a, s_alu_src_b, s_aluop;
    logic s_hasfunct7, s_illegal;
    logic [31:0] s_instret, s_cycle;

    always #5 clk = ~clk;

    riscv_mc_control #(.TRAP_HALT(1)) dut_h (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
        .mem_req_o(h_mem_req), .mem_read_o(h_mem_read), .mem_write_o(h_mem_write),
        .ir_write_o(h_ir_write), .pc_write_o(h_pc_write), .pc_src_o(h_pc_src),
        .reg_write_o(h_reg_write), .mem_to_reg_o(h_mem_to_reg), .alu_src_a_o(h_alu_src_a),
        .alu_src_b_o(h_alu_src_b), .aluop_o(h_aluop), .hasfunct7_o(h_hasfunct7),
        .illegal_o(h_illegal), .instret_o(h_instret), .cycle_o(h_cycle)
    );

    riscv_mc_control #(.TRAP_HALT(0)) dut_s (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
        .mem_req_o(s_mem_req), .mem_read_o(s_mem_read), .mem_write_o(s_mem_write),
        .ir_write_o(s_ir_write), .pc_write_o(s_pc_write), .pc_src_o(s_pc_src),
        .reg_write_o(s_reg_write), .mem_to_reg_o(s_mem_to_reg), .alu_src_a_o(s_alu_src_a),
        .alu_src_b_o(s_alu_src_b), .aluop_o(s_aluop), .hasfunct7_o(s_hasfunct7),
        .illegal_o(s_illegal), .instret_o(s_instret), .cycle_o(s_cycle)
    );

    logic [15:0] ctrl_h, ctrl_s;
    assign ctrl_h = {h_mem_req, h_mem_read, h_mem_write, h_ir_write, h_pc_write, h_pc_src,
                     h_reg_write, h_mem_to_reg, h_alu_src_a, h_alu_src_b, h_aluop, h_hasfunct7};
    assign ctrl_s = {s_mem_req, s_mem_read, s_mem_write, s_ir_write, s_pc_write, s_pc_src,
                     s_reg_write, s_mem_to_reg, s_alu_src_a, s_alu_src_b, s_aluop, s_hasfunct7};

    typedef enum int {
        P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_I, P_ADDR, P_MEM_RD,
        P_MEM_WB, P_MEM_WR, P_BRANCH, P_JAL, P_WB_ALU, P_TRAP
    } ph_t;

    // Reference model: index 0 tracks the halting instance, index 1 the skipping one.
    ph_t         ph  [2];
    bit          ill [2];
    logic [31:0] cyc [2];
    logic [31:0] ret [2];
    bit          mvalid = 1'b0;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] exp_ctrl(input ph_t p, input logic rdy, input logic z);
        logic req, rd, wr, irw, pcw, pcs, rw, f7;
        logic [1:0] m2r, a, b, op;
        req = 0; rd = 0; wr = 0; irw = 0; pcw = 0; pcs = 0; rw = 0; f7 = 0;
        m2r = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00;
        case (p)
            P_FETCH:  begin req = 1; rd = 1; b = 2'b01; irw = rdy; pcw = rdy; end
            P_DECODE: begin a = 2'b10; b = 2'b10; end
            P_EXEC_R: begin a = 2'b01; b = 2'b00; op = 2'b10; f7 = 1; end
            P_EXEC_I: begin a = 2'b01; b = 2'b10; op = 2'b10; end
            P_WB_ALU: begin rw = 1; end
            P_ADDR:   begin a = 2'b01; b = 2'b10; end
            P_MEM_RD: begin req = 1; rd = 1; end
            P_MEM_WB: begin rw = 1; m2r = 2'b01; end
            P_MEM_WR: begin req = 1; wr = 1; end
            P_BRANCH: begin a = 2'b01; op = 2'b01; pcs = 1; pcw = z; end
            P_JAL:    begin rw = 1; m2r = 2'b10; pcw = 1; pcs = 1; end
            default:  ;
        endcase
        return {req, rd, wr, irw, pcw, pcs, rw, m2r, a, b, op, f7};
    endfunction

    function automatic ph_t next_ph(input ph_t p, input logic [6:0] op, input logic rdy, input bit halt);
        case (p)
            P_FETCH:  return rdy ? P_DECODE : P_FETCH;
            P_DECODE: begin
                if (op == OPC_ADD)                     return P_EXEC_R;
                else if (op == OPC_ADDI)               return P_EXEC_I;
                else if (op == OPC_LW || op == OPC_SW) return P_ADDR;
                else if (op == OPC_BEQ)                return P_BRANCH;
                else if (op == OPC_JAL)                return P_JAL;
                else                                   return P_TRAP;
            end
            P_EXEC_R, P_EXEC_I: return P_WB_ALU;
            P_ADDR:   return op[5] ? P_MEM_WR : P_MEM_RD;
            P_MEM_RD: return rdy ? P_MEM_WB : P_MEM_RD;
            P_MEM_WR: return rdy ? P_FETCH : P_MEM_WR;
            P_TRAP:   return halt ? P_TRAP : P_FETCH;
            default:  return P_FETCH;
        endcase
    endfunction

    task automatic check_all();
        check("ctrl_h",    32'(ctrl_h),    32'(exp_ctrl(ph[0], ready, zero)));
        check("illegal_h", 32'(h_illegal), 32'(ill[0]));
        check("instret_h", h_instret,      PERF ? ret[0] : 32'd0);
        check("cycle_h",   h_cycle,        PERF ? cyc[0] : 32'd0);
        check("ctrl_s",    32'(ctrl_s),    32'(exp_ctrl(ph[1], ready, zero)));
        check("illegal_s", 32'(s_illegal), 32'(ill[1]));
        check("instret_s", s_instret,      PERF ? ret[1] : 32'd0);
        check("cycle_s",   s_cycle,        PERF ? cyc[1] : 32'd0);
    endtask

    // One clock cycle: drive inputs, check the cycle's outputs, then advance the model
    // to what the next rising edge should produce. Returns before that edge.
    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic rdy);
        ph_t nx;
        @(negedge clk);
        rst = r; opcode = op; zero = z; ready = rdy;
        #1;
        if (mvalid) check_all();
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                ph[k] = P_FETCH; ill[k] = 1'b0; cyc[k] = '0; ret[k] = '0;
            end else begin
                nx = next_ph(ph[k], op, rdy, k == 0);
                if (nx == P_FETCH && ph[k] != P_FETCH && ph[k] != P_TRAP) ret[k] = ret[k] + 32'd1;
                if (nx == P_TRAP) ill[k] = 1'b1;
                cyc[k] = cyc[k] + 32'd1;
                ph[k] = nx;
            end
        end
        if (r) mvalid = 1'b1;
    endtask

    initial begin
        logic [6:0] op;
        int sel;

        // add
        step(1, OPC_ADD, 0, 1);
        step(0, OPC_ADD, 0, 1);
        check("fetch_ir_write", 32'(h_ir_write), 32'd1);
        step(0, OPC_ADD, 0, 1);
        step(0, OPC_ADD, 0, 1);
        check("add_aluop", 32'(h_aluop), 32'd2);
        check("add_funct7", 32'(h_hasfunct7), 32'd1);
        step(0, OPC_ADD, 0, 1);
        check("add_reg_write", 32'(h_reg_write), 32'd1);
        step(0, OPC_ADD, 0, 0);
        check("add_instret", h_instret, PERF ? 32'd1 : 32'd0);

        // load with three wait cycles
        step(0, OPC_LW, 0, 1);
        step(0, OPC_LW, 0, 1);
        step(0, OPC_LW, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, OPC_LW, 0, (i == 3) ? 1'b1 : 1'b0);
            check("load_wait_strobes", 32'({h_mem_req, h_mem_read, h_mem_write}), 32'b110);
        end
        step(0, OPC_LW, 0, 1);
        check("load_mem_to_reg", 32'(h_mem_to_reg), 32'd1);

        // beq taken / not taken
        step(0, OPC_BEQ, 0, 1);
        step(0, OPC_BEQ, 0, 1);
        step(0, OPC_BEQ, 1, 1);
        check("beq_taken", 32'({h_pc_write, h_pc_src}), 32'b11);
        step(0, OPC_BEQ, 0, 1);
        step(0, OPC_BEQ, 0, 1);
        step(0, OPC_BEQ, 0, 1);
        check("beq_not_taken", 32'({h_pc_write, h_pc_src}), 32'b01);

        // illegal opcode
        step(0, OPC_BAD, 0, 1);
        step(0, OPC_BAD, 0, 1);
        step(0, OPC_BAD, 0, 0);
        check("trap_illegal_h", 32'(h_illegal), 32'd1);
        check("trap_illegal_s", 32'(s_illegal), 32'd1);
        step(0, OPC_BAD, 0, 0);
        check("trap_halt_stuck", 32'(h_mem_req), 32'd0);
        check("trap_skip_fetch", 32'(s_mem_req), 32'd1);
        step(0, OPC_BAD, 0, 0);
        check("trap_halt_still", 32'(h_mem_req), 32'd0);

        // reset while a store waits
        step(1, OPC_SW, 0, 1);
        step(0, OPC_SW, 0, 1);
        step(0, OPC_SW, 0, 1);
        step(0, OPC_SW, 0, 1);
        step(0, OPC_SW, 0, 0);
        check("store_wait_write", 32'(h_mem_write), 32'd1);
        step(1, OPC_SW, 0, 0);
        step(0, OPC_SW, 0, 0);
        check("rst_mem_write", 32'(h_mem_write), 32'd0);
        check("rst_fetch_req", 32'(h_mem_req), 32'd1);
        check("rst_cycle", h_cycle, 32'd0);
        check("rst_instret", h_instret, 32'd0);
        check("rst_illegal", 32'(s_illegal), 32'd0);

`ifdef RISCV_PERF_CNT_EN
        // preload the cycle counter just below the wrap point
        force dut_h.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut_h.cycle_cnt;
        cyc[0] = 32'd0;
        step(0, OPC_ADD, 0, 0);
        check("cycle_wrap", h_cycle, 32'd0);
`else
        step(0, OPC_ADD, 0, 0);
        check("perf_off", h_cycle | h_instret | s_cycle | s_instret, 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = OPC_ADD;
                1: op = OPC_ADDI;
                2: op = OPC_LW;
                3: op = OPC_SW;
                4: op = OPC_BEQ;
                5: op = OPC_JAL;
                6: op = 7'($urandom);
                default: op = OPC_BAD;
            endcase
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, op, 1'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
